// File: rtl/glove_gesture_decoder.sv
// Glove front end: syncs and debounces 5 finger bits, classifies the stable pattern, and requests one blit per new sign.
// Latency: 2 + DEBOUNCE_CYCLES + STABLE_CYCLES + 1 cycles from finger step to draw; draw is held until blit_busy acks.
module glove_gesture_decoder #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int STABLE_CYCLES   = 1000000,
    parameter int CNT_W           = 21
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [4:0] finger_in,
    input  logic       blit_busy,
    output logic       draw,
    output logic [2:0] sign_sel,
    output logic [4:0] pattern,
    output logic       sign_valid
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       SIGN_LAST_VALID = 3'd4;
    localparam logic [2:0]       SIGN_NONE       = 3'd6;
    localparam logic [2:0]       SIGN_BAD        = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ISSUE,
        ST_WAIT_DONE
    } state_t;

    function automatic logic [2:0] classify(input logic [4:0] p);
        logic [2:0] idx;
        case (p)
            5'b01111: idx = 3'd0;
            5'b10000: idx = 3'd1;
            5'b00111: idx = 3'd2;
            5'b01110: idx = 3'd3;
            5'b11000: idx = 3'd4;
            5'b00000: idx = SIGN_NONE;
            default:  idx = SIGN_BAD;
        endcase
        return idx;
    endfunction

    logic [4:0]       sync1_q, sync1_d;
    logic [4:0]       sync2_q, sync2_d;
    logic [4:0]       pattern_q, pattern_d;
    logic [CNT_W-1:0] deb_cnt_q [5];
    logic [CNT_W-1:0] deb_cnt_d [5];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [4:0]       cand_q, cand_d;
    logic [2:0]       last_sign_q, last_sign_d;
    logic             draw_q, draw_d;
    logic [2:0]       sign_sel_q, sign_sel_d;

    logic [2:0]       cur_sign;
    logic             cur_valid;

    assign cur_sign  = classify(pattern_q);
    assign cur_valid = (cur_sign <= SIGN_LAST_VALID);

    // finger_in is asynchronous to CLOCK_50; nothing downstream looks at it before sync2_q
    always_comb begin
        sync1_d = finger_in;
        sync2_d = sync1_q;
    end

    // Each bit must disagree with the accepted level for DEBOUNCE_CYCLES consecutive cycles to flip
    always_comb begin
        pattern_d = pattern_q;
        for (int i = 0; i < 5; i++) begin
            deb_cnt_d[i] = deb_cnt_q[i];
            if (sync2_q[i] == pattern_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                pattern_d[i] = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        cand_d       = cand_q;
        last_sign_d  = last_sign_q;
        draw_d       = draw_q;
        sign_sel_d   = sign_sel_q;
        case (state_q)
            ST_IDLE: begin
                // Returning to rest re-arms the same sign; other invalid patterns keep the memory
                if (pattern_q == 5'b00000) begin
                    last_sign_d = SIGN_NONE;
                end
                if (cur_valid && (cur_sign != last_sign_q)) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                    cand_d       = pattern_q;
                end
            end
            ST_SETTLE: begin
                // A pattern change beats a settle that would complete this cycle
                if (pattern_q != cand_q) begin
                    state_d      = ST_IDLE;
                    settle_cnt_d = '0;
                end else if (settle_cnt_q == STB_LAST) begin
                    state_d      = ST_ISSUE;
                    settle_cnt_d = '0;
                    sign_sel_d   = classify(cand_q);
                    draw_d       = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q + CNT_ONE;
                end
            end
            ST_ISSUE: begin
                if (blit_busy) begin
                    state_d     = ST_WAIT_DONE;
                    draw_d      = 1'b0;
                    last_sign_d = sign_sel_q;
                end
            end
            ST_WAIT_DONE: begin
                if (!blit_busy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                draw_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            pattern_q    <= '0;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i] <= '0;
            end
            state_q      <= ST_IDLE;
            settle_cnt_q <= '0;
            cand_q       <= '0;
            last_sign_q  <= SIGN_NONE;
            draw_q       <= 1'b0;
            sign_sel_q   <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            pattern_q    <= pattern_d;
            for (int i = 0; i < 5; i++) begin
                deb_cnt_q[i] <= deb_cnt_d[i];
            end
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            cand_q       <= cand_d;
            last_sign_q  <= last_sign_d;
            draw_q       <= draw_d;
            sign_sel_q   <= sign_sel_d;
        end
    end

    assign draw       = draw_q;
    assign sign_sel   = sign_sel_q;
    assign pattern    = pattern_q;
    assign sign_valid = cur_valid;

endmodule

// File: tb/tb_glove_gesture_decoder.sv
// Scoreboard bench for glove_gesture_decoder with DEBOUNCE_CYCLES=4, STABLE_CYCLES=8.
module tb_glove_gesture_decoder;

    logic       CLOCK_50;
    logic       resetn;
    logic [4:0] finger_in;
    logic       blit_busy;
    logic       draw;
    logic [2:0] sign_sel;
    logic [4:0] pattern;
    logic       sign_valid;

    glove_gesture_decoder #(
        .DEBOUNCE_CYCLES(4),
        .STABLE_CYCLES  (8),
        .CNT_W          (21)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .resetn    (resetn),
        .finger_in (finger_in),
        .blit_busy (blit_busy),
        .draw      (draw),
        .sign_sel  (sign_sel),
        .pattern   (pattern),
        .sign_valid(sign_valid)
    );

    typedef struct {
        int sign;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic draw_prev = 1'b0;

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    always @(posedge CLOCK_50) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Every draw rising edge must match the oldest expected request, in sign and in cycle
    always @(negedge CLOCK_50) begin
        if (draw === 1'b1 && draw_prev !== 1'b1) begin
            if (sb.size() == 0) begin
                chk("spurious_draw", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("draw_sign", int'(sign_sel), e.sign);
                chk("draw_cycle", cyc, e.cyc);
            end
        end
        draw_prev = draw;
    end

    // Apply a clean finger step; a new valid sign should draw 15 cycles later
    task automatic step(input logic [4:0] f, input bit expect_draw, input int sign, input int lat);
        finger_in = f;
        if (expect_draw) sb.push_back('{sign, cyc + lat});
    endtask

    task automatic wait_draw(input int bound);
        int n;
        n = 0;
        while (draw !== 1'b1 && n < bound) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("draw_seen", int'(draw), 1);
    endtask

    task automatic ack(input int hold);
        wait_draw(40);
        @(negedge CLOCK_50);
        chk("draw_held", int'(draw), 1);
        blit_busy = 1'b1;
        @(negedge CLOCK_50);
        chk("draw_drop_on_busy", int'(draw), 0);
        repeat (hold) @(negedge CLOCK_50);
        blit_busy = 1'b0;
        @(negedge CLOCK_50);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b0;
        finger_in = 5'b00000;
        blit_busy = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_draw", int'(draw), 0);
        chk("rst_sign_sel", int'(sign_sel), 0);
        chk("rst_pattern", int'(pattern), 0);
        chk("rst_sign_valid", int'(sign_valid), 0);
        resetn = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        // 1: clean step to sign 0
        step(5'b01111, 1'b1, 0, 15);
        wait_draw(40);
        chk("t1_pattern", int'(pattern), 5'b01111);
        chk("t1_valid", int'(sign_valid), 1);

        // 2: ack two cycles after rise, hold busy 20 cycles, then no redraw of the same sign
        @(negedge CLOCK_50);
        chk("t2_draw_held", int'(draw), 1);
        blit_busy = 1'b1;
        @(negedge CLOCK_50);
        chk("t2_draw_drop", int'(draw), 0);
        repeat (19) @(negedge CLOCK_50);
        blit_busy = 1'b0;
        repeat (30) @(negedge CLOCK_50);
        chk("t2_sel_stable", int'(sign_sel), 0);

        // 3: 3-cycle glitch on bit 3 during a 10000 hold
        step(5'b10000, 1'b1, 1, 15);
        repeat (8) @(negedge CLOCK_50);
        finger_in = 5'b11000;
        repeat (3) @(negedge CLOCK_50);
        finger_in = 5'b10000;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLOCK_50);
            chk("t3_pattern", int'(pattern), 5'b10000);
        end
        ack(5);

        // 4: 00111 lasts only 6 cycles as a debounced pattern, then 01110 takes over
        step(5'b00111, 1'b0, 0, 0);
        repeat (6) @(negedge CLOCK_50);
        chk("t4_pattern_a", int'(pattern), 5'b00111);
        // the aborting SETTLE->IDLE costs one cycle beyond the clean-step latency
        step(5'b01110, 1'b1, 3, 16);
        ack(5);
        chk("t4_pattern_b", int'(pattern), 5'b01110);

        // 5: sign 2, rest at 00000, sign 2 again, then an invalid pattern
        step(5'b00111, 1'b1, 2, 15);
        ack(4);
        step(5'b00000, 1'b0, 0, 0);
        repeat (15) @(negedge CLOCK_50);
        chk("t5_rest_valid", int'(sign_valid), 0);
        step(5'b00111, 1'b1, 2, 15);
        ack(4);
        step(5'b10101, 1'b0, 0, 0);
        repeat (10) @(negedge CLOCK_50);
        chk("t5_bad_pattern", int'(pattern), 5'b10101);
        chk("t5_bad_valid", int'(sign_valid), 0);
        repeat (30) @(negedge CLOCK_50);

        // 6: reset while draw is pending and busy is low
        step(5'b11000, 1'b1, 4, 15);
        wait_draw(40);
        resetn = 1'b0;
        @(negedge CLOCK_50);
        chk("t6_draw", int'(draw), 0);
        chk("t6_sign_sel", int'(sign_sel), 0);
        chk("t6_pattern", int'(pattern), 0);
        chk("t6_valid", int'(sign_valid), 0);
        resetn = 1'b1;
        sb.push_back('{4, cyc + 15});
        ack(3);

        // 7: busy already high when ISSUE is entered gives a one-cycle draw
        step(5'b01111, 1'b1, 0, 15);
        repeat (10) @(negedge CLOCK_50);
        blit_busy = 1'b1;
        wait_draw(40);
        @(negedge CLOCK_50);
        chk("t7_one_cycle_draw", int'(draw), 0);
        repeat (3) @(negedge CLOCK_50);
        blit_busy = 1'b0;
        repeat (20) @(negedge CLOCK_50);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
